// File: rtl/mux_sel_sched_pkg.sv
// ---------------------------------------------------------------------------
// mux_sel_sched_pkg
// Shared definitions for the mux select sequencer:
//   - SEL_W       : width of a mux select value (four mux inputs)
//   - state_t     : sequencer state encoding (IDLE / RUN / DONE)
//   - pick_t      : result of a next-index search (index + wrap flag)
//   - next_enabled: finds the next enabled mux input after 'cur' in the
//                   requested direction, or wraps to the start of that
//                   direction when there is none.
// ---------------------------------------------------------------------------
package mux_sel_sched_pkg;

   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [SEL_W-1:0] idx;
      logic             wrap;
   } pick_t;

   // dir = 0 searches upwards, dir = 1 searches downwards. When nothing is
   // enabled beyond cur in that direction, wrap is raised and idx is the first
   // enabled input in that direction (lowest when ascending, highest when
   // descending). With an all-zero mask idx simply stays at cur.
   function automatic pick_t next_enabled(input logic [3:0]       mask,
                                          input logic [SEL_W-1:0] cur,
                                          input logic             dir);
      pick_t res;
      logic  found;
      res.idx  = cur;
      res.wrap = 1'b1;
      found    = 1'b0;
      if (!dir) begin
         for (int i = 0; i < 4; i++) begin
            if (!found && mask[i] && (i > int'(cur))) begin
               res.idx  = SEL_W'(i);
               res.wrap = 1'b0;
               found    = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (!found && mask[i]) begin
               res.idx = SEL_W'(i);
               found   = 1'b1;
            end
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (!found && mask[i] && (i < int'(cur))) begin
               res.idx  = SEL_W'(i);
               res.wrap = 1'b0;
               found    = 1'b1;
            end
         end
         for (int i = 3; i >= 0; i--) begin
            if (!found && mask[i]) begin
               res.idx = SEL_W'(i);
               found   = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_sel_sched_pick.sv
// ---------------------------------------------------------------------------
// mux_sel_sched_pick
// Combinational next-index finder over a 4-bit enable mask. Used both for
// stepping through the sequence (ascending or descending) and for finding
// the lowest enabled input when a sequence starts.
// Ports:
//   i_mask : enabled mux inputs
//   i_cur  : current select index
//   i_dir  : 0 = ascending, 1 = descending
//   o_idx  : next enabled index (or first index of the direction on wrap)
//   o_wrap : no enabled index beyond i_cur in the chosen direction
// ---------------------------------------------------------------------------
module mux_sel_sched_pick
   import mux_sel_sched_pkg::*;
(
   input  logic [3:0]       i_mask,
   input  logic [SEL_W-1:0] i_cur,
   input  logic             i_dir,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_wrap
);

   pick_t w_res;

   // The search itself lives in the package so it can be reasoned about in
   // one place; this wrapper just gives it a hardware instance.
   always_comb begin
      w_res = next_enabled(i_mask, i_cur, i_dir);
   end

   assign o_idx  = w_res.idx;
   assign o_wrap = w_res.wrap;

endmodule

// File: rtl/mux_sel_sched.sv
// ---------------------------------------------------------------------------
// mux_sel_sched
// Sequencer driving the 2-bit select of a 4-way registered mux. Visits the
// enabled mux inputs in turn, holding each for its dwell count, for a
// programmed number of rounds.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   running         : accelerator running; low freezes the sequencer
//   run             : single-cycle start (also aborts/restarts a sequence)
//   en_mask         : bit i set = mux input i visited each round
//   dwell0..dwell3  : hold cycles per select (0 behaves as 1)
//   rounds          : number of passes over the enabled inputs
//   out0            : current select, zero-extended to DATA_W
//   valid           : out0 carries a scheduled select this cycle
//   done            : sequence complete, held until the next run
// Build option:
//   MUX_SEL_SCHED_PINGPONG_EN : odd rounds walk the inputs in descending
//   order, with each turnaround endpoint visited once per round.
// ---------------------------------------------------------------------------
module mux_sel_sched
   import mux_sel_sched_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int COUNT_W = 8,
   parameter int ROUND_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   input  logic [3:0]         en_mask,
   input  logic [COUNT_W-1:0] dwell0,
   input  logic [COUNT_W-1:0] dwell1,
   input  logic [COUNT_W-1:0] dwell2,
   input  logic [COUNT_W-1:0] dwell3,
   input  logic [ROUND_W-1:0] rounds,
   output logic [DATA_W-1:0]  out0,
   output logic               valid,
   output logic               done
);

   state_t             r_state;
   logic [3:0]         r_mask;
   logic [COUNT_W-1:0] r_dwell [4];
   logic [ROUND_W-1:0] r_rounds;
   logic [SEL_W-1:0]   r_sel;
   logic [COUNT_W-1:0] r_dwellCnt;
   logic [ROUND_W-1:0] r_roundCnt;
   logic               r_valid;
   logic               r_done;

   logic [COUNT_W-1:0] w_inDwell [4];
   logic [SEL_W-1:0]   w_firstIdx;
   logic               w_firstWrap;
   logic [SEL_W-1:0]   w_nextIdx;
   logic               w_nextWrap;
   logic [SEL_W-1:0]   w_advIdx;
   logic [ROUND_W-1:0] w_roundInc;
   logic               w_lastRound;
   logic               w_start;
   logic               w_dir;

`ifdef MUX_SEL_SCHED_PINGPONG_EN
   logic               r_dir;
   assign w_dir = r_dir;
`else
   assign w_dir = 1'b0;
`endif

   // A zero dwell still shows the select for one cycle, so the counter is
   // loaded with the number of extra cycles to hold.
   function automatic logic [COUNT_W-1:0] dwellLoad(input logic [COUNT_W-1:0] d);
      return (d == '0) ? '0 : d - COUNT_W'(1);
   endfunction

   assign w_inDwell[0] = dwell0;
   assign w_inDwell[1] = dwell1;
   assign w_inDwell[2] = dwell2;
   assign w_inDwell[3] = dwell3;

   // Starting an ascending search "after index 3" always wraps, which hands
   // back the lowest enabled input of the live mask.
   mux_sel_sched_pick u_pickFirst (
      .i_mask (en_mask),
      .i_cur  (SEL_W'(3)),
      .i_dir  (1'b0),
      .o_idx  (w_firstIdx),
      .o_wrap (w_firstWrap)
   );

   mux_sel_sched_pick u_pickNext (
      .i_mask (r_mask),
      .i_cur  (r_sel),
      .i_dir  (w_dir),
      .o_idx  (w_nextIdx),
      .o_wrap (w_nextWrap)
   );

   // In ping-pong mode the wrap point is where the direction turns, and the
   // endpoint we are sitting on opens the next round as well.
`ifdef MUX_SEL_SCHED_PINGPONG_EN
   assign w_advIdx = w_nextWrap ? r_sel : w_nextIdx;
`else
   assign w_advIdx = w_nextIdx;
`endif

   assign w_roundInc  = r_roundCnt + ROUND_W'(1);
   assign w_lastRound = (w_roundInc == r_rounds);
   assign w_start     = run && running;

   // Main sequencer: a start pulse (from any state) latches the shadow
   // configuration; RUN then counts dwell down, steps to the next enabled
   // input, and counts rounds on each wrap until the programmed count is hit.
   // With running low nothing moves and valid is withdrawn.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_mask     <= '0;
         r_dwell    <= '{default: '0};
         r_rounds   <= '0;
         r_sel      <= '0;
         r_dwellCnt <= '0;
         r_roundCnt <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
`ifdef MUX_SEL_SCHED_PINGPONG_EN
         r_dir      <= 1'b0;
`endif
      end else if (w_start) begin
         r_mask     <= en_mask;
         r_dwell    <= w_inDwell;
         r_rounds   <= rounds;
         r_roundCnt <= '0;
`ifdef MUX_SEL_SCHED_PINGPONG_EN
         r_dir      <= 1'b0;
`endif
         if ((en_mask == 4'd0) || (rounds == '0)) begin
            r_state    <= DONE;
            r_dwellCnt <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b1;
         end else begin
            r_state    <= RUN;
            r_sel      <= w_firstIdx;
            r_dwellCnt <= dwellLoad(w_inDwell[w_firstIdx]);
            r_valid    <= 1'b1;
            r_done     <= 1'b0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               r_valid <= 1'b0;
            end
            RUN: begin
               if (!running) begin
                  r_valid <= 1'b0;
               end else if (r_dwellCnt != '0) begin
                  r_dwellCnt <= r_dwellCnt - COUNT_W'(1);
                  r_valid    <= 1'b1;
               end else if (w_nextWrap && w_lastRound) begin
                  r_state <= DONE;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_sel      <= w_advIdx;
                  r_dwellCnt <= dwellLoad(r_dwell[w_advIdx]);
                  r_valid    <= 1'b1;
                  if (w_nextWrap) begin
                     r_roundCnt <= w_roundInc;
`ifdef MUX_SEL_SCHED_PINGPONG_EN
                     r_dir      <= ~r_dir;
`endif
                  end
               end
            end
            DONE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // Only the low bits carry the select; the rest of the datapath word is 0.
   always_comb begin
      out0             = '0;
      out0[SEL_W-1:0]  = r_sel;
   end

   assign valid = r_valid;
   assign done  = r_done;

   // The first-index finder's wrap output is always set by construction.
   logic w_unusedFirstWrap;
   assign w_unusedFirstWrap = w_firstWrap;

endmodule

// File: tb/tb_mux_sel_sched.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_sched
// Self-checking bench for mux_sel_sched. Every started sequence pushes its
// expected select stream into a queue; a negedge monitor pops one entry per
// valid cycle and compares it with out0. Directed scenarios cover reset,
// the basic sequence, empty configs, pausing, abort/restart, mid-run reset
// and a few random configurations.
// ---------------------------------------------------------------------------
module tb_mux_sel_sched;

   localparam int DATA_W  = 32;
   localparam int COUNT_W = 8;
   localparam int ROUND_W = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               running = 1'b1;
   logic               run = 1'b0;
   logic [3:0]         en_mask = '0;
   logic [COUNT_W-1:0] dwell0 = '0;
   logic [COUNT_W-1:0] dwell1 = '0;
   logic [COUNT_W-1:0] dwell2 = '0;
   logic [COUNT_W-1:0] dwell3 = '0;
   logic [ROUND_W-1:0] rounds = '0;
   logic [DATA_W-1:0]  out0;
   logic               valid;
   logic               done;

   int          numChecks = 0;
   int          numPassed = 0;
   logic [31:0] expQ [$];
   int          waited;

   mux_sel_sched #(
      .DATA_W  (DATA_W),
      .COUNT_W (COUNT_W),
      .ROUND_W (ROUND_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .running (running),
      .run     (run),
      .en_mask (en_mask),
      .dwell0  (dwell0),
      .dwell1  (dwell1),
      .dwell2  (dwell2),
      .dwell3  (dwell3),
      .rounds  (rounds),
      .out0    (out0),
      .valid   (valid),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs === exp) numPassed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference stream: each round lists the enabled inputs in order (reversed
   // on odd rounds in ping-pong builds), each repeated max(dwell,1) times.
   task automatic buildExpected(input logic [3:0] m, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input int rnd);
      logic [7:0] d [4];
      bit         desc;
      int         idx;
      int         reps;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int r = 0; r < rnd; r++) begin
`ifdef MUX_SEL_SCHED_PINGPONG_EN
         desc = (r % 2) == 1;
`else
         desc = 1'b0;
`endif
         for (int k = 0; k < 4; k++) begin
            idx = desc ? 3 - k : k;
            if (m[idx]) begin
               reps = (d[idx] == 8'd0) ? 1 : int'(d[idx]);
               for (int n = 0; n < reps; n++) expQ.push_back(32'(idx));
            end
         end
      end
   endtask

   // Pulses run with the given config, then scrambles the config inputs to
   // show they are only sampled at the start. Leaves time at cycle t1 + 1.
   task automatic applyStimulus(input logic [3:0] m, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input int rnd);
      @(posedge clk); #1;
      en_mask = m; dwell0 = d0; dwell1 = d1; dwell2 = d2; dwell3 = d3;
      rounds  = ROUND_W'(rnd);
      run     = 1'b1;
      @(posedge clk); #1;
      run     = 1'b0;
      en_mask = ~m; dwell0 = 8'hA5; dwell1 = 8'h5A; dwell2 = 8'hFF; dwell3 = 8'h07;
      rounds  = 16'hFFFF;
      expQ.delete();
      buildExpected(m, d0, d1, d2, d3, rnd);
   endtask

   // Bounded wait for done; reports how many cycles after t1 it took.
   task automatic waitDone(input int budget, output int cycles);
      cycles = 0;
      while (!done && cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("done seen", {31'b0, done}, 32'd1);
      checkOutput("valid at done", {31'b0, valid}, 32'd0);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
   endtask

   // Scoreboard consumer: one expected select per valid cycle.
   always @(negedge clk) begin
      if (!rst && valid) begin
         if (expQ.size() == 0) checkOutput("unexpected valid", {31'b0, valid}, 32'd0);
         else checkOutput("out0", out0, expQ.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset out0", out0, 32'd0);
      checkOutput("reset valid", {31'b0, valid}, 32'd0);
      checkOutput("reset done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle valid", {31'b0, valid}, 32'd0);

      // Basic sequence: 12 valid cycles, done from t13 and held
      applyStimulus(4'b1011, 8'd2, 8'd1, 8'd9, 8'd3, 2);
      waitDone(60, waited);
      checkOutput("basic length", 32'(waited), 32'd12);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("done held", {31'b0, done}, 32'd1);

      // Empty mask and zero rounds finish immediately with no valid cycles
      applyStimulus(4'b0000, 8'd1, 8'd1, 8'd1, 8'd1, 2);
      checkOutput("empty mask done", {31'b0, done}, 32'd1);
      waitDone(5, waited);
      applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1, 0);
      checkOutput("zero rounds done", {31'b0, done}, 32'd1);
      waitDone(5, waited);

      // Pause after four valid cycles: valid drops, out0 frozen on select 3
      applyStimulus(4'b1011, 8'd2, 8'd1, 8'd9, 8'd3, 2);
      checkOutput("restart clears done", {31'b0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      running = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("paused valid", {31'b0, valid}, 32'd0);
         checkOutput("paused out0", out0, 32'd3);
      end
      running = 1'b1;
      waitDone(60, waited);

      // Abort mid-run with a single-input config
      applyStimulus(4'b1011, 8'd2, 8'd1, 8'd9, 8'd3, 2);
      repeat (4) @(posedge clk);
      #1;
      applyStimulus(4'b0100, 8'd5, 8'd5, 8'd0, 8'd5, 3);
      waitDone(30, waited);
      checkOutput("abort length", 32'(waited), 32'd3);

      // Reset in the middle of a run
      applyStimulus(4'b1011, 8'd2, 8'd1, 8'd9, 8'd3, 2);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst out0", out0, 32'd0);
      checkOutput("midrst valid", {31'b0, valid}, 32'd0);
      checkOutput("midrst done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("post reset idle", {31'b0, valid}, 32'd0);

      // Unit dwell, two rounds (ping-pong order when that build is selected)
      applyStimulus(4'b1011, 8'd1, 8'd1, 8'd1, 8'd1, 2);
      waitDone(40, waited);
      checkOutput("unit dwell length", 32'(waited), 32'd6);

      // A few random configurations
      for (int t = 0; t < 4; t++) begin
         applyStimulus(4'($urandom_range(1, 15)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                       8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
         waitDone(200, waited);
      end

      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
